// File: rtl/huffman_ctrl.sv
// Sequencer for the Huffman encoder: clears and loads the code table from
// a synchronous table memory, then forwards n_words upstream words.
module huffman_ctrl #(
  parameter int W  = 8,
  parameter int AW = 4,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [AW:0]   n_ent,
  input  logic [CW-1:0] n_words,
  output logic          tbl_rd,
  output logic [AW-1:0] tbl_addr,
  input  logic [W-1:0]  tbl_d,
  input  logic [W-1:0]  tbl_h,
  input  logic [W-1:0]  tbl_w,
  input  logic [W-1:0]  s_data,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic          d_req,
  output logic [W-1:0]  d_in,
  output logic          en_in,
  output logic          ready_in,
  output logic [W-1:0]  d_conf,
  output logic [W-1:0]  h_conf,
  output logic [W-1:0]  w_conf,
  output logic          en_conf,
  output logic          new_conf,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLR   = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;
  localparam logic [2:0] S_RUN   = 3'd5;
  localparam logic [2:0] S_FIN   = 3'd6;

  logic [2:0]    state_q, state_d;
  logic [AW:0]   ne_q;
  logic [CW-1:0] rem_q;
  logic [AW-1:0] addr_q;
  logic          dcnt_q;
  logic          rdv_q;
  logic          en_conf_q;
  logic [W-1:0]  d_conf_q, h_conf_q, w_conf_q;
  logic          en_in_q;
  logic [W-1:0]  d_in_q;
  logic          err_q;

  logic st_acc;
  logic last_rd;
  logic xfer;
  logic w_ok;

  assign st_acc  = (state_q == S_IDLE) & start & ~abort;
  assign last_rd = ({1'b0, addr_q} + (AW+1)'(1)) == ne_q;
  assign s_ready = (state_q == S_RUN) & d_req & (rem_q != '0);
  assign xfer    = s_valid & s_ready;
  assign w_ok    = (tbl_w != '0) & (tbl_w <= W'(W));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_CLR;
      S_CLR:   state_d = (ne_q != '0) ? S_LOAD : S_GAP;
      S_LOAD:  if (last_rd) state_d = S_DRAIN;
      S_DRAIN: if (dcnt_q) state_d = S_GAP;
      S_GAP:   state_d = (rem_q == '0) ? S_FIN : S_RUN;
      S_RUN:   if (xfer && rem_q == CW'(1)) state_d = S_FIN;
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort) state_d = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ne_q      <= '0;
      rem_q     <= '0;
      addr_q    <= '0;
      dcnt_q    <= 1'b0;
      rdv_q     <= 1'b0;
      en_conf_q <= 1'b0;
      d_conf_q  <= '0;
      h_conf_q  <= '0;
      w_conf_q  <= '0;
      en_in_q   <= 1'b0;
      d_in_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (st_acc) begin
        ne_q   <= n_ent;
        rem_q  <= n_words;
        addr_q <= '0;
        err_q  <= 1'b0;
      end
      if (tbl_rd && !last_rd) addr_q <= addr_q + AW'(1);
      dcnt_q <= (state_q == S_DRAIN) ? ~dcnt_q : 1'b0;
      // Reads still in the memory pipeline are dropped on abort
      rdv_q     <= tbl_rd & ~abort;
      en_conf_q <= rdv_q & w_ok & ~abort;
      if (rdv_q && w_ok && !abort) begin
        d_conf_q <= tbl_d;
        h_conf_q <= tbl_h;
        w_conf_q <= tbl_w;
      end
      if (rdv_q && !w_ok && !abort) err_q <= 1'b1;
      en_in_q <= xfer & ~abort;
      if (xfer && !abort) d_in_q <= s_data;
      if (xfer) rem_q <= rem_q - CW'(1);
    end
  end

  assign tbl_rd   = (state_q == S_LOAD);
  assign tbl_addr = addr_q;
  assign new_conf = (state_q == S_CLR);
  assign ready_in = (state_q == S_RUN);
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_FIN);
  assign en_conf  = en_conf_q;
  assign d_conf   = d_conf_q;
  assign h_conf   = h_conf_q;
  assign w_conf   = w_conf_q;
  assign en_in    = en_in_q;
  assign d_in     = d_in_q;
  assign err      = err_q;

endmodule

// File: tb/tb_huffman_ctrl.sv
// Randomised bench for huffman_ctrl: timeline-based reference model
// compared every cycle, plus literal checks on the directed scenarios.
module tb_huffman_ctrl;
  localparam int W  = 8;
  localparam int AW = 4;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic [AW:0] n_ent = '0;
  logic [CW-1:0] n_words = '0;
  logic tbl_rd;
  logic [AW-1:0] tbl_addr;
  logic [W-1:0] tbl_d = '0, tbl_h = '0, tbl_w = '0;
  logic [W-1:0] s_data = '0;
  logic s_valid = 1'b0;
  logic s_ready;
  logic d_req = 1'b0;
  logic [W-1:0] d_in;
  logic en_in, ready_in;
  logic [W-1:0] d_conf, h_conf, w_conf;
  logic en_conf, new_conf, busy, done, err;

  huffman_ctrl #(.W(W), .AW(AW), .CW(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .n_ent(n_ent), .n_words(n_words),
    .tbl_rd(tbl_rd), .tbl_addr(tbl_addr),
    .tbl_d(tbl_d), .tbl_h(tbl_h), .tbl_w(tbl_w),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .d_req(d_req), .d_in(d_in), .en_in(en_in), .ready_in(ready_in),
    .d_conf(d_conf), .h_conf(h_conf), .w_conf(w_conf),
    .en_conf(en_conf), .new_conf(new_conf),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  logic [W-1:0] md [16];
  logic [W-1:0] mh [16];
  logic [W-1:0] mw [16];

  always @(posedge clk)
    if (tbl_rd) begin
      tbl_d <= md[tbl_addr];
      tbl_h <= mh[tbl_addr];
      tbl_w <= mw[tbl_addr];
    end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", nm, $time, a, e);
    end
  endtask

  // upstream source
  logic [W-1:0] srcq[$];
  int vprob = 100;
  int dmode = 2;
  int dphase = 0;
  bit hs;

  always begin
    @(negedge clk);
    hs = s_valid && s_ready;
    @(posedge clk);
    #1;
    if (hs && srcq.size() > 0) void'(srcq.pop_front());
    s_valid = (srcq.size() > 0) && ($urandom_range(99) < vprob);
    s_data = (srcq.size() > 0) ? srcq[0] : '0;
    case (dmode)
      0: d_req = 1'($urandom_range(1));
      1: begin
        d_req = (dphase % 4 == 0) || (dphase % 4 == 3);
        dphase++;
      end
      default: d_req = 1'b1;
    endcase
  end

  // reference model: sequence timeline counted from the accepted start
  bit act = 0, in_run = 0, fin = 0, beat_m = 0, err_m = 0;
  int k = 0, m_ne = 0, m_nw = 0, rem = 0, L = 0, idx = 0;
  logic [W-1:0] din_m = '0;
  bit chk_on = 0;
  bit e_rd, e_conf, e_ready, e_sready, e_done, e_en;

  int cyc = 0, acc_cyc = 0, done_cyc = 0;
  int nnew = 0, nrd = 0, nready = 0, ndone = 0;
  int first_rd = -1, first_conf = -1;
  bit err_at_done = 0;
  logic [3*W-1:0] conf_log[$];
  logic [W-1:0] in_log[$];

  function automatic bit good(input int i);
    return mw[i] != 0 && mw[i] <= W;
  endfunction

  always @(negedge clk) begin
    cyc++;
    L = (m_ne > 0) ? m_ne + 2 : 0;
    idx = k - 4;
    e_rd = act && k >= 2 && k <= 1 + m_ne;
    e_conf = act && k >= 4 && idx < m_ne && good(idx);
    if (act && k >= 4 && idx < m_ne && !good(idx)) err_m = 1;
    e_ready = act && in_run;
    e_sready = e_ready && d_req && rem > 0;
    e_done = act && fin;
    e_en = beat_m;
    if (chk_on) begin
      chk("busy", busy, act);
      chk("new_conf", new_conf, act && k == 1);
      chk("tbl_rd", tbl_rd, e_rd);
      if (e_rd) chk("tbl_addr", tbl_addr, k - 2);
      chk("en_conf", en_conf, e_conf);
      if (e_conf)
        chk("conf", {d_conf, h_conf, w_conf},
            {md[idx], mh[idx], mw[idx]});
      chk("ready_in", ready_in, e_ready);
      chk("s_ready", s_ready, e_sready);
      chk("en_in", en_in, e_en);
      chk("d_in", d_in, din_m);
      chk("done", done, e_done);
      chk("err", err, err_m);
    end
    if (new_conf) nnew++;
    if (tbl_rd) begin
      nrd++;
      if (first_rd < 0) first_rd = cyc;
    end
    if (en_conf) begin
      conf_log.push_back({d_conf, h_conf, w_conf});
      if (first_conf < 0) first_conf = cyc;
    end
    if (ready_in) nready++;
    if (en_in) in_log.push_back(d_in);
    if (done) begin
      ndone++;
      done_cyc = cyc;
      err_at_done = err;
    end
    beat_m = 0;
    if (rst) begin
      act = 0; err_m = 0; din_m = '0;
    end else if (!act) begin
      if (start && !abort) begin
        act = 1; k = 1; fin = 0; in_run = 0; err_m = 0;
        m_ne = int'(n_ent); m_nw = int'(n_words); rem = m_nw;
        acc_cyc = cyc;
      end
    end else if (abort || fin) begin
      act = 0;
    end else if (in_run) begin
      if (e_sready && s_valid) begin
        beat_m = 1; din_m = s_data; rem--;
        if (rem == 0) begin in_run = 0; fin = 1; end
      end
      k++;
    end else begin
      k++;
      if (k == 3 + L) begin
        if (m_nw == 0) fin = 1;
        else in_run = 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    nnew = 0; nrd = 0; nready = 0; ndone = 0;
    first_rd = -1; first_conf = -1;
    conf_log.delete(); in_log.delete();
  endtask

  task automatic start_seq(input int ne, input int nw);
    n_ent = (AW+1)'(ne);
    n_words = CW'(nw);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int maxc);
    int n = 0;
    while (n < maxc) begin
      @(negedge clk);
      if (!busy) break;
      n++;
    end
    if (n >= maxc) begin
      errors++;
      $display("FAIL wait_idle timeout after %0d cycles", maxc);
    end
    tick();
  endtask

  task automatic wait_ready(input int maxc);
    int n = 0;
    while (n < maxc) begin
      @(negedge clk);
      if (ready_in) break;
      n++;
    end
    if (n >= maxc) begin
      errors++;
      $display("FAIL wait_ready timeout after %0d cycles", maxc);
    end
    tick();
  endtask

  task automatic fill_src(input int n);
    for (int i = 0; i < n; i++) srcq.push_back(W'($urandom));
  endtask

  task automatic rand_table(input int n);
    for (int i = 0; i < n; i++) begin
      md[i] = W'($urandom);
      mh[i] = W'($urandom);
      mw[i] = W'($urandom_range(1, W));
    end
  endtask

  logic [3*W-1:0] exp1 [5];
  logic [W-1:0] exp_in [4];
  logic [W-1:0] pushed [3];

  initial begin
    exp1 = '{24'h110002, 24'h330102, 24'h663306,
             24'h776307, 24'h88C308};
    exp_in = '{8'h4C, 8'hE3, 8'hE1, 8'h63};
    for (int i = 0; i < 16; i++) begin
      md[i] = '0; mh[i] = '0; mw[i] = 8'd1;
    end
    tick();
    chk_on = 1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_outs", {tbl_rd, en_conf, en_in, ready_in, new_conf, done, err},
        0);
    chk("rst_regs", {d_in, d_conf, h_conf, w_conf}, 0);
    tick();

    // 1: five-entry load, four words
    md[0] = 8'h11; mh[0] = 8'h00; mw[0] = 8'd2;
    md[1] = 8'h33; mh[1] = 8'h01; mw[1] = 8'd2;
    md[2] = 8'h66; mh[2] = 8'h33; mw[2] = 8'd6;
    md[3] = 8'h77; mh[3] = 8'h63; mw[3] = 8'd7;
    md[4] = 8'h88; mh[4] = 8'hC3; mw[4] = 8'd8;
    for (int i = 0; i < 4; i++) srcq.push_back(exp_in[i]);
    vprob = 100; dmode = 2;
    clear_logs();
    start_seq(5, 4);
    wait_idle(200);
    chk("t1_nconf", conf_log.size(), 5);
    for (int i = 0; i < 5 && i < conf_log.size(); i++)
      chk("t1_conf", conf_log[i], exp1[i]);
    chk("t1_nin", in_log.size(), 4);
    for (int i = 0; i < 4 && i < in_log.size(); i++)
      chk("t1_din", in_log[i], exp_in[i]);
    chk("t1_newconf", nnew, 1);
    chk("t1_rd2conf", first_conf - first_rd, 2);
    chk("t1_done", ndone, 1);

    // 2: d_req pattern 1,0,0,1 with valid gaps, extra words left over
    rand_table(3);
    srcq.delete();
    for (int i = 0; i < 3; i++) begin
      pushed[i] = W'($urandom);
      srcq.push_back(pushed[i]);
    end
    fill_src(2);
    vprob = 60; dmode = 1; dphase = 0;
    clear_logs();
    start_seq(3, 3);
    wait_idle(400);
    chk("t2_nin", in_log.size(), 3);
    for (int i = 0; i < 3 && i < in_log.size(); i++)
      chk("t2_din", in_log[i], pushed[i]);
    srcq.delete();

    // 3: bad widths at entries 1 and 3
    rand_table(4);
    mw[1] = 8'd0; mw[3] = 8'd9;
    fill_src(2);
    vprob = 100; dmode = 0;
    clear_logs();
    start_seq(4, 2);
    wait_idle(400);
    chk("t3_nconf", conf_log.size(), 2);
    chk("t3_err_done", err_at_done, 1);
    chk("t3_err_sticky", err, 1);

    // 4: empty sequence, also clears err
    clear_logs();
    start_seq(0, 0);
    @(negedge clk);
    chk("t4_err_clr", err, 0);
    tick();
    wait_idle(50);
    chk("t4_done_lat", done_cyc - acc_cyc, 3);
    chk("t4_nrd", nrd, 0);
    chk("t4_nready", nready, 0);
    chk("t4_newconf", nnew, 1);

    // 5: abort in LOAD, abort in RUN, then a full run
    rand_table(10);
    clear_logs();
    start_seq(10, 5);
    repeat (4) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    @(negedge clk);
    chk("t5_busy_load", busy, 0);
    tick();
    fill_src(5);
    start_seq(3, 5);
    wait_ready(100);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    @(negedge clk);
    chk("t5_strobes_run", {busy, en_in, ready_in, en_conf, tbl_rd}, 0);
    tick();
    chk("t5_nodone", ndone, 0);
    srcq.delete();
    rand_table(4);
    fill_src(6);
    clear_logs();
    start_seq(4, 6);
    wait_idle(400);
    chk("t5_full_done", ndone, 1);
    chk("t5_full_nin", in_log.size(), 6);

    // 6: start while busy, reset in RUN
    rand_table(8);
    fill_src(50);
    start_seq(8, 50);
    repeat (3) tick();
    n_ent = 5'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_ready(100);
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("t6_busy", busy, 0);
    chk("t6_outs", {en_in, ready_in, en_conf, tbl_rd, done, err, d_in}, 0);
    tick();
    srcq.delete();

    // random sequences with occasional aborts
    for (int r = 0; r < 8; r++) begin
      int ne, nw;
      ne = $urandom_range(0, 16);
      nw = $urandom_range(0, 20);
      rand_table(16);
      if ($urandom_range(1) == 1) mw[$urandom_range(0, 15)] = 8'd0;
      srcq.delete();
      fill_src(nw + 3);
      vprob = $urandom_range(40, 100);
      dmode = 0;
      start_seq(ne, nw);
      if ($urandom_range(3) == 0) begin
        repeat ($urandom_range(1, 20)) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
      end
      wait_idle(2000);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/huffman_ctrl.md
Name: huffman_ctrl

Overview:
- Sequencer in front of the Huffman_enc datapath.
- On `start`, it clears the encoder's code table with a `new_conf` pulse, then streams table entries from a synchronous-read table memory onto `d_conf`/`h_conf`/`w_conf` with `en_conf`.
- It then enters the operational phase: asserts `ready_in` and forwards exactly `n_words` coded words from an upstream valid/ready source onto `d_in`/`en_in`, gated by the encoder's `d_req`.
- Reports `busy`/`done`/`err` to the system controller.

Parameters:
W, 8, data/code/width bus width (matches Huffman_enc W)
AW, 4, table address width; max entries 2**AW
CW, 16, word-count width

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-high
start  in  1  one-cycle pulse; begins sequence when idle, ignored when busy
abort  in  1  synchronous abort of running sequence
n_ent  in  AW+1  number of table entries to load (0..2**AW)
n_words  in  CW  number of coded words to forward
tbl_rd  out  1  table read strobe
tbl_addr  out  AW  table read address
tbl_d  in  W  table: decoded symbol, valid 1 cycle after tbl_rd
tbl_h  in  W  table: Huffman code, right-justified
tbl_w  in  W  table: code width
s_data  in  W  upstream coded word
s_valid  in  1  upstream valid
s_ready  out  1  upstream ready (combinational)
d_req  in  1  encoder requests next word
d_in  out  W  word to encoder
en_in  out  1  d_in valid
ready_in  out  1  operational phase active
d_conf, h_conf, w_conf  out  W each  config entry to encoder
en_conf  out  1  config entry valid
new_conf  out  1  clear encoder table
busy  out  1  sequence in progress
done  out  1  one-cycle completion pulse
err  out  1  sticky bad-width flag

Behaviour:
- Reset:
  - State is IDLE.
  - All outputs are 0, including registered `d_in`/`d_conf`/`h_conf`/`w_conf`.
  - Counters are cleared and `err` is cleared.
- `n_ent`, `n_words`: latched on accepted `start`; must not affect the sequence afterwards.
- IDLE:
  - `busy`=0.
  - On `start`: clear `err`, go to CLR.
- CLR:
  - `new_conf`=1 for exactly one cycle; `busy`=1.
  - Next state: LOAD if latched `n_ent`>0, else GAP.
- LOAD:
  - `tbl_rd`=1 with `tbl_addr`=0,1,…,n_ent-1 on consecutive cycles.
  - Read issued in cycle t ⇒ `tbl_*` sampled at the end of t+1 ⇒ `d_conf`/`h_conf`/`w_conf` registered and `en_conf`=1 during t+2.
  - `en_conf` is therefore high for up to n_ent back-to-back cycles, starting 2 cycles after the first `tbl_rd`.
  - After the last read, go to DRAIN and wait 2 cycles for the pipeline to empty, then go to GAP.
- Width check:
  - An entry with `tbl_w`==0 or `tbl_w`>W sets `err` (sticky until next accepted `start` or `rst`).
  - That entry is suppressed (`en_conf`=0 in its slot); the sequence continues.
- GAP:
  - One idle cycle.
  - Next state: RUN with `ready_in`=1 registered; if latched `n_words`==0, go directly to FIN instead.
- RUN:
  - `ready_in`=1.
  - `s_ready` = RUN & `d_req` & (remaining>0).
  - On `s_valid`&`s_ready` in cycle t:
    - `d_in`<=`s_data` and `en_in`=1 in t+1.
    - remaining decrements.
  - Otherwise `en_in`=0 and `d_in` holds its value.
  - When the final transfer is accepted, go to FIN.
- FIN:
  - `ready_in`<=0; last `en_in` beat is still emitted this cycle.
  - `done`=1 for one cycle, then IDLE.
- `abort` (any non-IDLE state):
  - Next cycle is IDLE.
  - `tbl_rd`, `en_conf`, `en_in`, `ready_in`, `busy` all 0.
  - No `done` pulse; in-flight table reads are discarded.
  - `abort` has priority over every transition; in IDLE it has no effect.
- `start` and `abort` in the same cycle while IDLE: `abort` wins, `start` is ignored.
- `rst` mid-sequence: same as reset values; `err` is cleared.
- Counter wrap: remaining is CW bits; `n_words`=2**CW-1 must run to completion without wrap. `tbl_addr` never exceeds n_ent-1.

Test Plan:
1. Load 5 entries {(d=11,h=00,w=2),(33,01,2),(66,110011,6),(77,1100011,7),(88,11000011,8)}, n_words=4 → `new_conf` 1 cycle; `en_conf` 5 consecutive cycles with exact values; then 4 `en_in` beats equal to the s_data sequence {0x4C,0xE3,0xE1,0x63}; `done` pulse; `busy` low.
2. `d_req` toggling 1,0,0,1 and `s_valid` gaps during RUN with n_words=3 → `en_in` asserted only one cycle after `d_req`&`s_valid`; exactly 3 beats; no beat after count reaches 0.
3. Entry 2 of 4 has w=0, another has w=9 → those slots have `en_conf`=0; `err`=1 and stays set through `done`; cleared on next `start`.
4. n_ent=0, n_words=0 → `new_conf` pulse, no `tbl_rd`, `ready_in` never high, `done` 3 cycles after `start`.
5. `abort` in the middle of LOAD and again in the middle of RUN → IDLE next cycle; all strobes 0; no `done`; a following `start` runs a full correct sequence.
6. `start` pulsed while busy, and `rst` asserted mid-RUN → `start` ignored; after `rst` all outputs are 0 and `busy`=0.
